// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow clk-asynchronous square wave in clk cycles,
// with timeout on missing rising edges and a stability flag for repeated equal periods.
module clk_period_meter #(
  parameter int CNT_W   = 20,
  parameter int TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             meas_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             timeout,
  output logic             stable
);

  typedef enum logic [1:0] {IDLE, WAIT_FIRST, MEASURE, TMO} state_t;

  localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_cap_q, hi_cap_d;
  logic [CNT_W-1:0] prev_period_q, prev_period_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             stable_q, stable_d;

  logic             rise, fall;
  logic [CNT_W-1:0] cnt_inc;

  assign rise    = s2_q & ~s3_q;
  assign fall    = ~s2_q & s3_q;
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hi_cap_d      = hi_cap_q;
    prev_period_d = prev_period_q;
    period_d      = period_q;
    high_time_d   = high_time_q;
    valid_d       = 1'b0;
    timeout_d     = timeout_q;
    stable_d      = stable_q;

    if (!en) begin
      state_d   = IDLE;
      cnt_d     = '0;
      timeout_d = 1'b0;
      stable_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT_FIRST;
          cnt_d   = '0;
        end
        WAIT_FIRST, MEASURE: begin
          // A rise on the limit cycle still counts as a valid period of exactly TIMEOUT.
          if (rise) begin
            state_d = MEASURE;
            cnt_d   = '0;
            if (state_q == MEASURE) begin
              period_d      = cnt_inc;
              high_time_d   = hi_cap_q;
              valid_d       = 1'b1;
              prev_period_d = cnt_inc;
              stable_d      = (cnt_inc == prev_period_q) && (prev_period_q != '0);
            end
          end else if (cnt_inc == TMO_LIM) begin
            state_d       = TMO;
            timeout_d     = 1'b1;
            stable_d      = 1'b0;
            prev_period_d = '0;
            cnt_d         = '0;
          end else begin
            cnt_d = cnt_inc;
            if (fall && state_q == MEASURE) hi_cap_d = cnt_inc;
          end
        end
        TMO: begin
          if (rise) begin
            state_d   = MEASURE;
            timeout_d = 1'b0;
            cnt_d     = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      s3_q          <= 1'b0;
      cnt_q         <= '0;
      hi_cap_q      <= '0;
      prev_period_q <= '0;
      period_q      <= '0;
      high_time_q   <= '0;
      valid_q       <= 1'b0;
      timeout_q     <= 1'b0;
      stable_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      s1_q          <= meas_in;
      s2_q          <= s1_q;
      s3_q          <= s2_q;
      cnt_q         <= cnt_d;
      hi_cap_q      <= hi_cap_d;
      prev_period_q <= prev_period_d;
      period_q      <= period_d;
      high_time_q   <= high_time_d;
      valid_q       <= valid_d;
      timeout_q     <= timeout_d;
      stable_q      <= stable_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_time_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;
  assign stable    = stable_q;

endmodule
